// File: rtl/menu_pkg.sv
// menu_pkg: shared constants and types for the on-screen button menu.
//   - RGB332 colour constants (red[7:5], green[4:2], blue[1:0])
//   - menu FSM state enum
//   - screen geometry of the active video area
//   - bit positions of the three buttons in the conditioned-button vectors
package menu_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [7:0] COL_BLACK   = 8'b000_000_00;
  localparam logic [7:0] COL_HILITE  = 8'b111_111_00;  // yellow
  localparam logic [7:0] COL_CONFIRM = 8'b000_111_00;  // green

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_SEL  = 2;

  typedef enum logic {
    NAV  = 1'b0,
    CONF = 1'b1
  } menu_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw asynchronous push button.
//   Parameter: DEBOUNCE_CYC - stable cycles required before a level is accepted.
//   Ports:
//     clock   in  pixel clock
//     reset_n in  asynchronous active-low reset
//     raw     in  raw button level (asynchronous, active-high)
//     pulse   out one-cycle pulse on each rising edge of the accepted level
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          sync2_d;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= 1'b0;
      if (sync2 != sync2_d) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Counter parks at its maximum while the level stays put, so a held
        // button only ever yields the single pulse of its accepting cycle.
        level <= sync2_d;
        pulse <= sync2_d & ~level;
      end
    end
  end

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: on-screen button menu sequencer and pixel compositor.
//   Optional build macro: MENU_WRAP_EN - selection wraps at the ends of the
//   list instead of saturating.
//   Ports:
//     clock, reset_n              pixel clock, asynchronous active-low reset
//     btn_up/btn_down/btn_sel     raw asynchronous buttons
//     hcount, vcount              current pixel position
//     ovl_data, ovl_red/green/blue overlay pixel valid and colour
//     ovl_enable                  overlay renderer enable (set at first frame tick)
//     sel_idx                     selected item index
//     item_sel                    one-cycle confirm pulse on a frame tick
//     red, green, blue            composed pixel, one clock after the inputs
module menu_ctrl #(
  parameter int N_ITEMS        = 4,
  parameter int BASE_X         = 250,
  parameter int BASE_Y         = 120,
  parameter int ITEM_W         = 140,
  parameter int ITEM_H         = 20,
  parameter int ITEM_PITCH     = 40,
  parameter int V_ACTIVE       = menu_pkg::V_ACTIVE,
  parameter int DEBOUNCE_CYC   = 250000,
  parameter int CONFIRM_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       ovl_data,
  input  logic [2:0] ovl_red,
  input  logic [2:0] ovl_green,
  input  logic [1:0] ovl_blue,
  output logic       ovl_enable,
  output logic [2:0] sel_idx,
  output logic       item_sel,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  import menu_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(N_ITEMS - 1);
  localparam int FW = (CONFIRM_FRAMES > 1) ? $clog2(CONFIRM_FRAMES) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(CONFIRM_FRAMES - 1);

  localparam logic [10:0] X_LEFT  = 11'(BASE_X - 1);
  localparam logic [10:0] X_RIGHT = 11'(BASE_X + ITEM_W);

  // ---------------- button conditioning ----------------
  logic [2:0] raw;
  logic [2:0] pulse;
  logic [2:0] pend;

  assign raw = {btn_sel, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_btn (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    (raw[gi]),
        .pulse  (pulse[gi])
      );
    end
  endgenerate

  logic tick;
  assign tick = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);

  // Flags are consumed on every tick; a pulse coinciding with the tick
  // survives into the next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else if (tick) begin
      pend <= pulse;
    end else begin
      pend <= pend | pulse;
    end
  end

  // ---------------- menu FSM ----------------
  menu_state_t   state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [FW-1:0] fcnt_reg, fcnt_next;
  logic          ovl_en_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= NAV;
      idx_reg    <= '0;
      fcnt_reg   <= '0;
      ovl_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      fcnt_reg  <= fcnt_next;
      if (tick) ovl_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    fcnt_next  = fcnt_reg;
    item_sel   = 1'b0;
    if (tick) begin
      case (state_reg)
        NAV: begin
          if (pend[BTN_SEL]) begin
            item_sel   = 1'b1;
            fcnt_next  = '0;
            state_next = CONF;
          end else if (pend[BTN_UP] && !pend[BTN_DOWN]) begin
`ifdef MENU_WRAP_EN
            idx_next = (idx_reg == 3'd0) ? LAST_IDX : idx_reg - 3'd1;
`else
            if (idx_reg != 3'd0) idx_next = idx_reg - 3'd1;
`endif
          end else if (pend[BTN_DOWN] && !pend[BTN_UP]) begin
`ifdef MENU_WRAP_EN
            idx_next = (idx_reg == LAST_IDX) ? 3'd0 : idx_reg + 3'd1;
`else
            if (idx_reg != LAST_IDX) idx_next = idx_reg + 3'd1;
`endif
          end
        end
        CONF: begin
          fcnt_next = fcnt_reg + 1'b1;
          if (fcnt_reg == FC_LAST) state_next = NAV;
        end
        default: state_next = NAV;
      endcase
    end
  end

  assign sel_idx    = idx_reg;
  assign ovl_enable = ovl_en_reg;

  // ---------------- pixel path ----------------
  logic [9:0]  prod;
  logic [10:0] px, py, y_top, y_bot;
  logic        visible, in_box, border;
  logic [7:0]  rgb_next, rgb_reg;

  assign prod    = 10'(idx_reg * ITEM_PITCH);
  assign px      = {1'b0, hcount};
  assign py      = {1'b0, vcount};
  assign y_top   = 11'(BASE_Y) + {1'b0, prod} - 11'd1;
  assign y_bot   = 11'(BASE_Y) + {1'b0, prod} + 11'(ITEM_H);
  assign visible = (px < 11'(H_ACTIVE)) && (py < 11'(V_ACTIVE));
  assign in_box  = (px >= X_LEFT) && (px <= X_RIGHT) && (py >= y_top) && (py <= y_bot);
  assign border  = in_box && ((px == X_LEFT) || (px == X_RIGHT) ||
                              (py == y_top)  || (py == y_bot));

  // Output stays black until the first tick so a reset mid-frame never
  // paints a partial frame.
  always_comb begin
    rgb_next = COL_BLACK;
    if (visible && ovl_en_reg) begin
      if (ovl_data) begin
        rgb_next = {ovl_red, ovl_green, ovl_blue};
      end else if (border) begin
        rgb_next = (state_reg == CONF) ? COL_CONFIRM : COL_HILITE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_reg <= COL_BLACK;
    end else begin
      rgb_reg <= rgb_next;
    end
  end

  assign red   = rgb_reg[7:5];
  assign green = rgb_reg[4:2];
  assign blue  = rgb_reg[1:0];

endmodule

// File: tb/tb_menu_ctrl.sv
module tb_menu_ctrl;

  localparam logic [7:0] YEL   = 8'b111_111_00;
  localparam logic [7:0] GRN   = 8'b000_111_00;
  localparam logic [7:0] BLK   = 8'b000_000_00;
  localparam logic [7:0] OVLC  = 8'b101_010_11;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_up, btn_down, btn_sel;
  logic [9:0] hcount, vcount;
  logic       ovl_data;
  logic [2:0] ovl_red, ovl_green;
  logic [1:0] ovl_blue;
  logic       ovl_enable;
  logic [2:0] sel_idx;
  logic       item_sel;
  logic [2:0] red, green;
  logic [1:0] blue;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_idx;

  always #5 clock = ~clock;

  menu_ctrl #(
    .DEBOUNCE_CYC  (4),
    .CONFIRM_FRAMES(2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_sel   (btn_sel),
    .hcount    (hcount),
    .vcount    (vcount),
    .ovl_data  (ovl_data),
    .ovl_red   (ovl_red),
    .ovl_green (ovl_green),
    .ovl_blue  (ovl_blue),
    .ovl_enable(ovl_enable),
    .sel_idx   (sel_idx),
    .item_sel  (item_sel),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("[%0t] %s observed 0x%0h expected 0x%0h", $time, tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_pos();
    hcount   = 10'd700;
    vcount   = 10'd0;
    ovl_data = 1'b0;
  endtask

  // Hold a button mask, release it, then let the release settle.
  task automatic press(input logic [2:0] m, input int hold);
    {btn_sel, btn_down, btn_up} = m;
    cycles(hold);
    {btn_sel, btn_down, btn_up} = 3'b000;
    cycles(10);
  endtask

  task automatic do_tick(input string tag, input logic exp_sel);
    hcount = 10'd0;
    vcount = 10'd480;
    #1;
    check({tag, "_item_sel"}, {7'd0, item_sel}, {7'd0, exp_sel});
    cycles(1);
    idle_pos();
    #1;
    check({tag, "_item_sel_after"}, {7'd0, item_sel}, 8'd0);
  endtask

  task automatic check_idx(input string tag, input int e);
    check(tag, {5'd0, sel_idx}, 8'(e));
  endtask

  task automatic check_px(input string tag, input int h, input int v,
                          input logic od, input logic [7:0] oc, input logic [7:0] exp);
    hcount   = 10'(h);
    vcount   = 10'(v);
    ovl_data = od;
    {ovl_red, ovl_green, ovl_blue} = oc;
    cycles(1);
    check(tag, {red, green, blue}, exp);
    idle_pos();
  endtask

  initial begin
    reset_n = 1'b0;
    {btn_sel, btn_down, btn_up} = 3'b000;
    {ovl_red, ovl_green, ovl_blue} = 8'd0;
    idle_pos();
    cycles(3);
    check("reset_sel_idx", {5'd0, sel_idx}, 8'd0);
    check("reset_item_sel", {7'd0, item_sel}, 8'd0);
    check("reset_ovl_enable", {7'd0, ovl_enable}, 8'd0);
    check("reset_rgb", {red, green, blue}, BLK);
    reset_n = 1'b1;
    cycles(2);

    // Down held 10 cycles -> one step at the tick, nothing on a later tick.
    press(3'b010, 10);
    do_tick("down_tick", 1'b0);
    check_idx("down_idx", 1);
    check("ovl_enable_after_tick", {7'd0, ovl_enable}, 8'd1);
    do_tick("idle_tick", 1'b0);
    check_idx("idle_idx", 1);

    // 2-cycle glitch is rejected.
    press(3'b010, 2);
    do_tick("glitch_tick", 1'b0);
    check_idx("glitch_idx", 1);

    // Up to 0, then up at 0.
    press(3'b001, 10);
    do_tick("up_tick", 1'b0);
    check_idx("up_idx", 0);
    press(3'b001, 10);
    do_tick("up0_tick", 1'b0);
`ifdef MENU_WRAP_EN
    check_idx("up0_idx_wrap", 3);
    press(3'b010, 10);
    do_tick("down3_tick", 1'b0);
    check_idx("down3_idx_wrap", 0);
    exp_idx = 0;
`else
    check_idx("up0_idx_sat", 0);
    for (int i = 1; i <= 3; i++) begin
      press(3'b010, 10);
      do_tick("walk_tick", 1'b0);
      check_idx("walk_idx", i);
    end
    press(3'b010, 10);
    do_tick("down3_tick", 1'b0);
    check_idx("down3_idx_sat", 3);
    exp_idx = 3;
`endif

    // Up and down together cancel.
    press(3'b011, 10);
    do_tick("both_tick", 1'b0);
    check_idx("both_idx", exp_idx);

    // Select with down: confirm pulse, no move, confirm colour.
    press(3'b110, 10);
    do_tick("sel_tick", 1'b1);
    check_idx("sel_idx_kept", exp_idx);
    check_px("conf_border", 249, 120 + exp_idx * 40 - 1, 1'b0, 8'd0, GRN);
    press(3'b010, 10);
    do_tick("conf_tick1", 1'b0);
    check_idx("conf_down_ignored", exp_idx);
    check_px("conf_border2", 249, 120 + exp_idx * 40 - 1, 1'b0, 8'd0, GRN);
    do_tick("conf_tick2", 1'b0);
    check_idx("nav_idx", exp_idx);
    check_px("nav_border", 249, 120 + exp_idx * 40 - 1, 1'b0, 8'd0, YEL);

    // Move to item 1 for the pixel checks.
`ifdef MENU_WRAP_EN
    press(3'b010, 10);
    do_tick("to1_tick", 1'b0);
`else
    press(3'b001, 10);
    do_tick("to2_tick", 1'b0);
    press(3'b001, 10);
    do_tick("to1_tick", 1'b0);
`endif
    check_idx("at1_idx", 1);
    check_px("px_border_corner", 249, 159, 1'b0, 8'd0, YEL);
    check_px("px_inside", 255, 165, 1'b0, 8'd0, BLK);
    check_px("px_right_edge", 390, 170, 1'b0, 8'd0, YEL);
    check_px("px_bottom_edge", 300, 180, 1'b0, 8'd0, YEL);
    check_px("px_below_box", 300, 181, 1'b0, 8'd0, BLK);
    check_px("px_ovl_wins", 249, 159, 1'b1, OVLC, OVLC);
    check_px("px_offscreen", 700, 10, 1'b1, OVLC, BLK);

    // Reset mid-line.
    hcount = 10'd249;
    vcount = 10'd159;
    cycles(1);
    check("pre_reset_rgb", {red, green, blue}, YEL);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_rgb", {red, green, blue}, BLK);
    check("midreset_idx", {5'd0, sel_idx}, 8'd0);
    cycles(2);
    reset_n = 1'b1;
    check_px("post_reset_black", 249, 119, 1'b0, 8'd0, BLK);
    do_tick("resume_tick", 1'b0);
    check_px("post_tick_border", 249, 119, 1'b0, 8'd0, YEL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
- Sequences the on-screen button menu.
- Conditions three raw push buttons (sync, debounce, edge detect) and maintains the selected item index.
- Applies index changes only at frame boundaries and positions the button overlay's enable.
- Composes the final per-pixel RGB: overlay pixels, a highlight frame around the selected item, and a background.

Parameters:
- N_ITEMS, 4, number of menu items (2..8).
- BASE_X, 250, left x of item column (pixels).
- BASE_Y, 120, top y of item 0 (pixels).
- ITEM_W, 140, item width (pixels).
- ITEM_H, 20, item height (pixels).
- ITEM_PITCH, 40, vertical distance between item tops (pixels, > ITEM_H+2).
- V_ACTIVE, 480, first non-visible line; frame tick source.
- DEBOUNCE_CYC, 250000, stable cycles required per button (10 ms at 25 MHz).
- CONFIRM_FRAMES, 30, frames the confirm colour is held.

Ports:
- clock  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw button, asynchronous, active-high.
- btn_down  in  1  raw button, asynchronous, active-high.
- btn_sel  in  1  raw button, asynchronous, active-high.
- hcount  in  10  current pixel x.
- vcount  in  10  current pixel y.
- ovl_data  in  1  overlay pixel valid.
- ovl_red  in  3  overlay colour.
- ovl_green  in  3  overlay colour.
- ovl_blue  in  2  overlay colour.
- ovl_enable  out  1  enable to overlay renderer.
- sel_idx  out  3  selected item, 0..N_ITEMS-1.
- item_sel  out  1  one-cycle pulse at confirm (frame tick).
- red  out  3  composed pixel.
- green  out  3  composed pixel.
- blue  out  2  composed pixel.

Behaviour:
Reset values:
- sel_idx=0, item_sel=0, ovl_enable=0, red/green/blue=0.
- FSM=NAV; all debounce counters and pending flags cleared.

Button conditioning (per button):
- 2-flop synchroniser.
- Counter resets on any change of the synced level; the stable level is accepted when the count reaches DEBOUNCE_CYC-1.
- Rising edge of the accepted level sets that button's pending flag.
- Holding a button produces one event only.

Frame tick:
- One-cycle strobe when vcount==V_ACTIVE and hcount==0.
- Pending flags are consumed and cleared only on the tick.
- An edge arriving in the same cycle as the tick is kept for the next tick.

FSM:
- NAV, on tick:
  - sel pending -> item_sel=1 for that cycle, frame counter=0, go CONF; pending up/down discarded.
  - else up and down both pending -> cancel both, no move.
  - else up -> sel_idx-1; down -> sel_idx+1.
  - Boundary: saturate at 0 and N_ITEMS-1 (see optional feature).
- CONF:
  - On each tick, counter+1; all pending flags discarded.
  - When counter == CONFIRM_FRAMES-1 on a tick -> NAV.
- ovl_enable=1 from the first tick after reset onward (overlay not shown during the partial first frame).

Pixel path (registered, latency 1 clock from hcount/vcount/ovl_* to red/green/blue):
- Selected box: x in [BASE_X-1, BASE_X+ITEM_W], y in [BASE_Y+sel_idx*ITEM_PITCH-1, that+ITEM_H]. Border = the 1-pixel perimeter of that box.
- Priority: ovl_data=1 -> ovl colour; else border -> yellow (111,111,00) in NAV or green (000,111,00) in CONF; else black.
- Outside visible area (hcount>=640 or vcount>=V_ACTIVE) -> black.
- The sel_idx*ITEM_PITCH product is computed into 10 bits; parameters are guaranteed to fit.
- Reset mid-frame: outputs go black immediately; normal output resumes after the next tick.

Optional Feature:
- MENU_WRAP_EN defined: up at 0 -> N_ITEMS-1; down at N_ITEMS-1 -> 0.
- Undefined: saturate at the ends (the move is dropped, sel_idx unchanged).

Decomposition:
- Package menu_pkg holds:
  - Colour constants (COL_BLACK, COL_HILITE, COL_CONFIRM as 8-bit RGB332).
  - FSM state enum {NAV, CONF}.
  - Screen constants H_ACTIVE=640, V_ACTIVE=480.
- Sub-module btn_debounce (parameter DEBOUNCE_CYC): sync, counter, rising-edge pulse; instantiated three times.

Test Plan (DEBOUNCE_CYC=4 and CONFIRM_FRAMES=2 in the bench):
- Reset, then btn_down held 10 cycles before tick -> sel_idx 0->1 at tick; a second tick with no new press -> sel_idx stays 1.
- btn_down glitch of 2 cycles -> no event; sel_idx unchanged after tick.
- sel_idx=0, btn_up press -> tick: sel_idx stays 0 without MENU_WRAP_EN, becomes 3 with it. Repeat at 3 with btn_down.
- btn_up and btn_down both pressed before the same tick -> sel_idx unchanged.
- btn_sel and btn_down pressed before the same tick -> item_sel high exactly 1 cycle at tick, sel_idx unchanged, FSM CONF. A down press during CONF is ignored; NAV returns after 2 ticks.
- sel_idx=1, no overlay: pixel (BASE_X-1, BASE_Y+39) -> yellow one clock later; pixel (BASE_X+5, BASE_Y+45) -> black. With ovl_data=1, red=101 on a border pixel -> overlay colour wins. Assert reset_n low mid-line -> RGB=0 immediately.
